serial_add_arb: RTL and testbench
=================================

SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 SHALL have parameter: W, 16, operand/result width in bits (W >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: req0  input  1  requester 0 operation request, level, held until done0.
REQ-005 SHALL have port: a0, b0  input  W each  requester 0 operands, stable while req0 high.
REQ-006 SHALL have port: sub0  input  1  requester 0 op select: 0 = a+b, 1 = a-b.
REQ-007 SHALL have ports req1, a1, b1, sub1 identical to REQ-004..006 for requester 1.
REQ-008 SHALL have port: gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-009 SHALL have port: done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have port: result  output  W  sum/difference of the last completed op.
REQ-011 SHALL have port: cout  output  1  final carry out of the last op.
REQ-012 SHALL have port: ovf  output  1  two's-complement overflow of the last op.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ADD, DONE; IDLE->ADD on accept, ADD->DONE after W bit cycles, DONE->IDLE unconditionally.
REQ-015 SHALL accept in IDLE when either req is high, latching the selected operands, sub bit, and owner ID at that edge.
REQ-016 SHALL arbitrate round-robin: single requester wins; when both request, the one not served last wins; after reset, requester 0 wins a tie.
REQ-017 SHALL register gnt of the winner high for exactly the cycle following the accept edge.
REQ-018 SHALL process one bit per cycle in ADD, LSB first, through a single 1-bit full adder, with the carry held in a flop.
REQ-019 SHALL, for sub=1, feed the inverted b bit and set the initial carry to 1; for sub=0, the initial carry SHALL be 0.
REQ-020 SHALL count bit cycles with a ceil(log2 W)-bit counter cleared on accept; the counter SHALL NOT wrap within an op.
REQ-021 SHALL raise done of the owner exactly W cycles after its gnt rises, for one cycle (DONE state).
REQ-022 SHALL update result, cout, and ovf only on entry to DONE, and SHALL hold them until the next DONE.
REQ-023 SHALL compute ovf as carry into MSB XOR carry out of MSB.
REQ-024 SHALL NOT arbitrate in DONE; a req still high after done SHALL be treated as a new request in the following IDLE cycle.
REQ-025 SHALL complete an op whose req drops mid-operation, still pulsing done for the owner.
REQ-026 SHALL give a minimum accept-to-accept spacing of W+2 cycles.

Reset
REQ-027 SHALL, on rst, immediately set state to IDLE, clear counter, carry, and operand registers, and set the round-robin pointer to favour requester 0.
REQ-028 SHALL drive all outputs to 0 while rst is high (result, cout, ovf, gnt*, done*, busy).
REQ-029 SHALL, when rst is asserted mid-operation, abort the op with no done pulse; the next op after release SHALL be correct.

Structure
REQ-030 SHALL place the state enum (IDLE, ADD, DONE) and the default width constant in a shared package, serial_add_pkg.
REQ-031 SHALL instantiate the team's existing 1-bit full-adder module FA as its sole sub-module; no other adder logic is permitted.

Verification
REQ-032 SHALL be checked by: req0, a0=0xFFFF, b0=0x0001, sub0=0 -> done0 16 cycles after gnt0; result=0x0000, cout=1, ovf=0.
REQ-033 SHALL be checked by: req1, a1=0x0005, b1=0x0007, sub1=1 -> result=0xFFFE, cout=0, ovf=0; done1 only.
REQ-034 SHALL be checked by: req0, a0=0x7FFF, b0=0x0001, add -> result=0x8000, ovf=1, cout=0.
REQ-035 SHALL be checked by: req0 and req1 high together from reset and held -> gnt0, then gnt1, then gnt0 again; grants spaced 18 cycles apart.
REQ-036 SHALL be checked by: rst pulsed 8 cycles into an op -> all outputs 0 at once, no done; then 0x1234+0x1111 -> 0x2345.
REQ-037 SHALL be checked by: req0 dropped 3 cycles after gnt0 -> done0 still pulses, with result from the latched operands.

Source files
------------

// File: rtl/serial_add_arb_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared state encoding and default width for serial_add_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int unsigned c_default_w = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_arb_fa.sv
// ============================================================================
// Module      : FA
// Description : Single-bit full adder shared by the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module FA (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/serial_add_arb.sv
// ============================================================================
// Module      : serial_add_arb
// Description : Two-requester round-robin front end to a bit-serial add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_arb
    import serial_add_pkg::*;
#(
    parameter int W = c_default_w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         sub0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         sub1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    localparam int c_cw = $clog2(W);

    state_t          r_state;
    state_t          w_next;
    logic [c_cw-1:0] r_cnt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-2:0]    r_acc;
    logic [W-1:0]    r_result;
    logic            r_sub;
    logic            r_carry;
    logic            r_owner;
    logic            r_last;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_cout;
    logic            r_ovf;

    logic            w_accept;
    logic            w_win;
    logic            w_last_bit;
    logic            w_s;
    logic            w_co;
    logic [W-1:0]    w_acc_next;

    assign w_accept   = (r_state == IDLE) && (req0 || req1);
    // On a tie the requester not served last wins; r_last resets to 1 so 0 wins first.
    assign w_win      = (req0 && req1) ? ~r_last : req1;
    assign w_last_bit = (r_cnt == c_cw'(W - 1));
    assign w_acc_next = {w_s, r_acc};

    FA u_fa (
        .i_a  (r_a[0]),
        .i_b  (r_b[0] ^ r_sub),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ADD;
            ADD:     if (w_last_bit) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != IDLE);
        done0 = (r_state == DONE) && !r_owner;
        done1 = (r_state == DONE) &&  r_owner;
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_gnt0 <= w_accept && !w_win;
            r_gnt1 <= w_accept &&  w_win;
            if (w_accept) begin
                r_a     <= w_win ? a1 : a0;
                r_b     <= w_win ? b1 : b0;
                r_sub   <= w_win ? sub1 : sub0;
                r_carry <= w_win ? sub1 : sub0;
                r_owner <= w_win;
                r_last  <= w_win;
                r_cnt   <= '0;
            end else if (r_state == ADD) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_acc   <= w_acc_next[W-1:1];
                r_carry <= w_co;
                // MSB step: r_carry is the carry into the MSB, w_co the carry out.
                if (w_last_bit) begin
                    r_result <= w_acc_next;
                    r_cout   <= w_co;
                    r_ovf    <= r_carry ^ w_co;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_arb.sv
// ============================================================================
// Module      : tb_serial_add_arb
// Description : Self-checking bench for serial_add_arb against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_add_arb;
    import serial_add_pkg::*;

    localparam int W = c_default_w;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, done0, done1, cout, ovf, busy;
    logic [W-1:0] result;

    int vectors = 0;
    int miscompares = 0;

    serial_add_arb #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t: 0 idle, 1 grant cycle, 2..W computing, W+1 done cycle.
    int           m_t = 0;
    logic         m_owner = 1'b0, m_last = 1'b1;
    logic [W+1:0] m_pend = '0;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0;

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    // Returns {ovf, cout, result} from plain arithmetic.
    function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         c, v;
        longint       sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            r    = full[W-1:0];
            c    = full[W];
            sr   = sa + sb;
        end
        v = (sr > (64'sd1 <<< (W-1)) - 1) || (sr < -(64'sd1 <<< (W-1)));
        return {v, c, r};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t    <= 0;
            m_last <= 1'b1;
            m_owner <= 1'b0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_t == 0) begin
            if (req0 || req1) begin
                m_owner <= pick(req0, req1, m_last);
                m_last  <= pick(req0, req1, m_last);
                m_pend  <= pick(req0, req1, m_last) ? calc(a1, b1, sub1) : calc(a0, b0, sub0);
                m_t     <= 1;
            end
        end else if (m_t == W + 1) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == W) {m_ovf, m_cout, m_res} <= m_pend;
        end
    end

    always @(negedge clk) begin
        check("outputs",
              {gnt0, gnt1, done0, done1, busy, cout, ovf, result},
              {(m_t == 1) && !m_owner, (m_t == 1) && m_owner,
               (m_t == W + 1) && !m_owner, (m_t == W + 1) && m_owner,
               m_t != 0, m_cout, m_ovf, m_res});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (who) begin a1 = a; b1 = b; sub1 = s; req1 = 1'b1; end
        else     begin a0 = a; b0 = b; sub0 = s; req0 = 1'b1; end
    endtask

    task automatic run_op(input string tag, input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
        int n;
        bit other;
        drive(who, a, b, s);
        n = 0;
        do begin tick(); n++; end while (!(who ? gnt1 : gnt0) && n < 40);
        check({tag, " gnt"}, who ? gnt1 : gnt0, 1);
        n = 0;
        other = 0;
        while (n < W + 4) begin
            tick();
            n++;
            if (who ? done0 : done1) other = 1;
            if (who ? done1 : done0) break;
        end
        check({tag, " gnt-to-done"}, n, W);
        check({tag, " other done"}, other, 0);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, ev);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int gt[$];
        int gw[$];
        bit seen;

        tick();
        tick();
        check("reset state", {gnt0, gnt1, done0, done1, busy, cout, ovf, result}, '0);
        rst = 1'b0;
        tick();

        run_op("ffff+1",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("5-7",     1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("7fff+1",  1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Both requesters from reset, held.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h1111, 16'h2222, 1'b0);
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        for (int c = 0; c < 80 && gt.size() < 3; c++) begin
            tick();
            if (gnt0) begin gt.push_back(c); gw.push_back(0); end
            if (gnt1) begin gt.push_back(c); gw.push_back(1); end
        end
        check("rr grant count", gt.size(), 3);
        if (gt.size() >= 3) begin
            check("rr first",   gw[0], 0);
            check("rr second",  gw[1], 1);
            check("rr third",   gw[2], 0);
            check("rr spacing1", gt[1] - gt[0], 18);
            check("rr spacing2", gt[2] - gt[1], 18);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        check("rr drain", busy, 0);
        tick();

        // Reset in the middle of an op.
        drive(1'b0, 16'hABCD, 16'h1357, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!gnt0 && n < 40);
        repeat (8) tick();
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        check("async reset outputs", {gnt0, gnt1, done0, done1, busy, cout, ovf, result}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin tick(); if (done0 || done1) seen = 1; end
        check("no done after abort", seen, 0);
        run_op("1234+1111", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Request dropped mid-operation; operands scrambled after the drop.
        drive(1'b0, 16'h00FF, 16'h0F01, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!gnt0 && n < 40);
        repeat (3) tick();
        req0 = 1'b0;
        a0 = W'($urandom);
        b0 = W'($urandom);
        n = 0;
        while (!done0 && n < W + 4) begin tick(); n++; end
        check("dropped req done0", done0, 1);
        check("dropped req result", result, 16'h1000);
        tick();
        tick();

        // Randomised traffic, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!req0) begin
                if ($urandom_range(0, 3) == 0) drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
            end else if (done0) begin
                if ($urandom_range(0, 1) == 0) req0 = 1'b0;
            end else if (gnt0 && $urandom_range(0, 7) == 0) begin
                req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(0, 3) == 0) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
            end else if (done1) begin
                if ($urandom_range(0, 1) == 0) req1 = 1'b0;
            end else if (gnt1 && $urandom_range(0, 7) == 0) begin
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (W + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
